cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 65 ++++++
 rtl/cpu_sequencer_ctrl_decode.sv | 48 ++++
 rtl/cpu_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared CPU definitions: sequencer states,
// opcodes, ALU selects and opcode class helpers.
package cpu_sequencer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SLT = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
    logic       jump;
    logic       beq;
    logic       bne;
  } ctrl_t;

  function automatic logic is_mem(
    input logic [3:0] op
  );
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_alu(
    input logic [3:0] op
  );
    return (op >= OP_ADD) && (op <= OP_SLT);
  endfunction

  function automatic logic is_branch(
    input logic [3:0] op
  );
    return (op == OP_BEQ) || (op == OP_BNE)
        || (op == OP_JMP);
  endfunction

  function automatic logic is_illegal(
    input logic [3:0] op
  );
    return !(is_mem(op) || is_alu(op)
          || is_branch(op));
  endfunction

endpackage

// File: rtl/cpu_sequencer_ctrl_decode.sv
// Static datapath controls from the latched
// opcode and the current sequencer state.
module ctrl_decode
  import cpu_sequencer_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] op_q,
  output ctrl_t      ctl
);

  logic act;
  logic ex;

  assign ex  = (state == S_EXEC);
  assign act = ex || (state == S_MEM)
            || (state == S_WB);

  // Per-class control set, live only in EXEC/MEM/WB
  always_comb begin
    ctl = '0;
    if (act) begin
      unique case (1'b1)
        is_mem(op_q): begin
          ctl.alu_src = 1'b1;
          ctl.alu_op  = ALU_ADD;
        end
        is_alu(op_q): begin
          ctl.reg_dst = 1'b1;
          // ADD..SLT map to 0..7; low bits wrap
          ctl.alu_op  = op_q[2:0] - 3'd2;
        end
        (op_q == OP_BEQ): begin
          ctl.alu_op = ALU_SUB;
          ctl.beq    = ex;
        end
        (op_q == OP_BNE): begin
          ctl.alu_op = ALU_SUB;
          ctl.bne    = ex;
        end
        (op_q == OP_JMP): begin
          ctl.jump = ex;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FSM,
// memory wait timeout and retire counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        jump,
  output logic        beq,
  output logic        bne,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        fault,
  output logic [15:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [3:0]    op_q;
  logic [TW-1:0] tcnt_q;
  logic [15:0]   retired_q;
  logic          retire;
  logic          to_hit;
  ctrl_t         ctl;

  assign to_hit = (tcnt_q == TW'(MEM_TIMEOUT - 1));

  // Next state plus per-state strobes
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write = run_en;
        state_d  = run_en ? S_DECODE : S_IDLE;
      end
      S_DECODE: begin
        state_d = is_illegal(opcode)
                ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_mem(op_q): state_d = S_MEM;
          is_alu(op_q): state_d = S_WB;
          is_branch(op_q): begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LD);
        mem_write = (op_q == OP_ST);
        if (mem_ready) begin
          if (op_q == OP_ST) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LD);
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // State, opcode latch, wait counter, retire count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      tcnt_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (state_q == S_EXEC) begin
        tcnt_q <= '0;
      end else if (state_q == S_MEM
                   && !mem_ready) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

  ctrl_decode u_dec (
    .state (state_q),
    .op_q  (op_q),
    .ctl   (ctl)
  );

  assign {alu_src, reg_dst, alu_op,
          jump, beq, bne} = ctl;
  assign state   = state_q;
  assign fault   = (state_q == S_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer against an
// instruction-level trace model.
module tb_cpu_sequencer;

  localparam int TO = 15;

  typedef struct packed {
    logic ir, pc, jmp, beq, bne, mr, mw;
    logic as, rd, m2r, rw;
    logic [2:0] aop;
  } ctl_t;

  typedef struct packed {
    logic [2:0]  st;
    ctl_t        c;
    logic        flt;
    logic [15:0] ret;
  } exp_t;

  logic        clk;
  logic        rst_n, run_en, mem_ready;
  logic [3:0]  opcode;
  logic        pc_write, ir_write, jump, beq, bne;
  logic        mem_read, mem_write, alu_src, reg_dst;
  logic        mem_to_reg, reg_write, fault;
  logic [2:0]  alu_op, state;
  logic [15:0] retired;
  ctl_t        act_c;

  int          n_chk = 0;
  int          n_err = 0;
  int          ncyc = 0;
  int          mr_cnt = 0;
  int          len, k;
  exp_t        ex;
  logic        chk_en = 1'b0;
  logic [15:0] m_ret = '0;
  logic        faulted = 1'b0;
  logic        in_idle = 1'b1;

  cpu_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_en     (run_en),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .state      (state),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign act_c = {ir_write, pc_write, jump, beq,
                  bne, mem_read, mem_write,
                  alu_src, reg_dst, mem_to_reg,
                  reg_write, alu_op};

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, a, e, $time);
    end
  endtask

  // Per-cycle compare against the model trace
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      chk("state", 32'(state), 32'(ex.st));
      chk("ctl", 32'(act_c), 32'(ex.c));
      chk("fault", 32'(fault), 32'(ex.flt));
      chk("retired", 32'(retired), 32'(ex.ret));
      if (mem_read) mr_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic rb();
    return $urandom_range(1) != 0;
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(15));
  endfunction

  function automatic exp_t mk(input logic [2:0] st,
                              input logic flt);
    exp_t e;
    e.st  = st;
    e.c   = '0;
    e.flt = flt;
    e.ret = m_ret;
    return e;
  endfunction

  // Controls every EXEC/MEM/WB cycle carries
  function automatic ctl_t stat(input logic [3:0] op);
    ctl_t c;
    logic [3:0] t;
    c = '0;
    t = op - 4'd2;
    if (op <= 4'd1) begin
      c.as = 1'b1;
    end else if (op <= 4'd9) begin
      c.rd  = 1'b1;
      c.aop = t[2:0];
    end else if (op == 4'hB || op == 4'hC) begin
      c.aop = 3'd1;
    end
    return c;
  endfunction

  task automatic step(input exp_t e,
                      input logic ce,
                      input logic rn,
                      input logic run,
                      input logic [3:0] opc,
                      input logic mr);
    @(negedge clk);
    rst_n     = rn;
    run_en    = run;
    opcode    = opc;
    mem_ready = mr;
    ex        = e;
    chk_en    = ce;
    ncyc++;
  endtask

  task automatic do_reset();
    step(mk(3'd0, 1'b0), 1'b0, 1'b0, 1'b0,
         r4(), rb());
    m_ret   = '0;
    faulted = 1'b0;
    step(mk(3'd0, 1'b0), 1'b1, 1'b0, 1'b0,
         r4(), rb());
    step(mk(3'd0, 1'b0), 1'b1, 1'b1, 1'b0,
         r4(), rb());
    in_idle = 1'b1;
  endtask

  task automatic fault_cycles(input int n);
    for (int i = 0; i < n; i++)
      step(mk(3'd7, 1'b1), 1'b1, 1'b1, rb(),
           r4(), rb());
  endtask

  task automatic pause(input int n);
    step(mk(3'd1, 1'b0), 1'b1, 1'b1, 1'b0,
         r4(), rb());
    for (int i = 0; i < n; i++)
      step(mk(3'd0, 1'b0), 1'b1, 1'b1, 1'b0,
           r4(), rb());
    in_idle = 1'b1;
  endtask

  // One instruction: w not-ready MEM cycles,
  // reset asserted at MEM cycle rst_at (if >= 0)
  task automatic do_instr(input logic [3:0] op,
                          input int w,
                          input int rst_at,
                          output int n);
    exp_t e;
    ctl_t c;
    logic rdy;
    int   n0;
    if (in_idle) begin
      step(mk(3'd0, 1'b0), 1'b1, 1'b1, 1'b1,
           r4(), rb());
      in_idle = 1'b0;
    end
    n0 = ncyc;
    e = mk(3'd1, 1'b0);
    e.c.ir = 1'b1;
    step(e, 1'b1, 1'b1, 1'b1, r4(), rb());
    e = mk(3'd2, 1'b0);
    step(e, 1'b1, 1'b1, rb(), op, rb());
    if (op == 4'hA || op >= 4'hE) begin
      faulted = 1'b1;
      n = ncyc - n0;
      return;
    end
    c = stat(op);
    e = mk(3'd3, 1'b0);
    e.c = c;
    if (op >= 4'hB) begin
      e.c.pc  = 1'b1;
      e.c.jmp = (op == 4'hD);
      e.c.beq = (op == 4'hB);
      e.c.bne = (op == 4'hC);
      step(e, 1'b1, 1'b1, rb(), r4(), rb());
      m_ret++;
      n = ncyc - n0;
      return;
    end
    step(e, 1'b1, 1'b1, rb(), r4(), rb());
    if (op >= 4'h2) begin
      e = mk(3'd5, 1'b0);
      e.c = c;
      e.c.rw = 1'b1;
      e.c.pc = 1'b1;
      step(e, 1'b1, 1'b1, rb(), r4(), rb());
      m_ret++;
      n = ncyc - n0;
      return;
    end
    for (int i = 0; i < TO; i++) begin
      rdy = (i == w);
      e = mk(3'd4, 1'b0);
      e.c = c;
      e.c.mr = (op == 4'h0);
      e.c.mw = (op == 4'h1);
      e.c.pc = (op == 4'h1) && rdy;
      if (i == rst_at) begin
        step(e, 1'b1, 1'b0, rb(), r4(), 1'b0);
        m_ret = '0;
        step(mk(3'd0, 1'b0), 1'b1, 1'b1, 1'b0,
             r4(), rb());
        in_idle = 1'b1;
        n = ncyc - n0;
        return;
      end
      step(e, 1'b1, 1'b1, rb(), r4(), rdy);
      if (rdy) break;
      if (i == TO - 1) begin
        faulted = 1'b1;
        n = ncyc - n0;
        return;
      end
    end
    if (op == 4'h1) begin
      m_ret++;
      n = ncyc - n0;
      return;
    end
    e = mk(3'd5, 1'b0);
    e.c = c;
    e.c.rw  = 1'b1;
    e.c.m2r = 1'b1;
    e.c.pc  = 1'b1;
    step(e, 1'b1, 1'b1, rb(), r4(), rb());
    m_ret++;
    n = ncyc - n0;
  endtask

  initial begin
    logic [3:0] op;
    int w;
    rst_n = 1'b0;
    run_en = 1'b0;
    opcode = '0;
    mem_ready = 1'b0;

    do_reset();
    #1 chk("rst_state", 32'(state), 0);

    do_instr(4'h2, 0, -1, len);
    chk("add_len", len, 4);
    chk("add_mret", 32'(m_ret), 1);
    pause(1);
    #1 chk("add_ret_dut", 32'(retired), 1);

    do_reset();
    do_instr(4'hB, 0, -1, len);
    chk("beq_len", len, 3);
    do_instr(4'hD, 0, -1, len);
    chk("jmp_len", len, 3);
    pause(0);
    #1 chk("br_ret_dut", 32'(retired), 2);

    do_reset();
    k = mr_cnt;
    do_instr(4'h0, 2, -1, len);
    chk("ld_len", len, 7);
    chk("ld_mr_cycles", mr_cnt - k, 3);
    do_instr(4'h1, 14, -1, len);
    chk("st_w14_len", len, 18);
    chk("st_w14_fault", 32'(faulted), 0);

    do_instr(4'h1, 99, -1, len);
    chk("to_len", len, 18);
    fault_cycles(3);
    #1 chk("to_state", 32'(state), 7);
    chk("to_fault", 32'(fault), 1);
    do_reset();
    #1 chk("to_clr", 32'(state), 0);

    do_instr(4'h3, 0, -1, len);
    do_instr(4'hE, 0, -1, len);
    chk("ill_len", len, 2);
    fault_cycles(2);
    #1 chk("ill_ret", 32'(retired), 1);
    do_reset();

    chk_en = 1'b0;
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    m_ret = 16'hFFFF;
    do_instr(4'h9, 0, -1, len);
    chk("wrap_mret", 32'(m_ret), 0);
    pause(0);
    #1 chk("wrap_dut", 32'(retired), 0);

    do_instr(4'h0, 3, 1, len);
    #1 chk("rst_mem_state", 32'(state), 0);
    chk("rst_mem_rd", 32'(mem_read), 0);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(99) < 4) begin
        k = $urandom_range(2);
        op = (k == 0) ? 4'hA : 4'(13 + k);
      end else begin
        k = $urandom_range(12);
        op = (k < 10) ? 4'(k) : 4'(k + 1);
      end
      w = ($urandom_range(99) < 4)
        ? 20 : $urandom_range(4);
      do_instr(op, w, -1, len);
      if (faulted) begin
        fault_cycles($urandom_range(3) + 1);
        do_reset();
      end else if ($urandom_range(4) == 0) begin
        pause($urandom_range(3));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
